// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
//   Shared RV64 load/store definitions. The core's decode and the data-memory
//   responder use the same tables.
//   - funct3 size/sign encodings for loads and stores
//   - FSM state encoding of the data-memory responder
//   - helpers that classify a funct3 / offset pair as illegal or misaligned
// ---------------------------------------------------------------------------
package rv_pkg;

    // funct3 size/sign codes. Bits [1:0] give log2 of the access size.
    // Bit 2 selects zero-extension on loads.
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    // Responder FSM encoding. These are plain constants so that older code
    // that compares raw state bits keeps working.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // The access must start on a multiple of its own size.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] offset);
        case (f3[1:0])
            2'b01:   return offset[0];
            2'b10:   return |offset[1:0];
            2'b11:   return |offset;
            default: return 1'b0;
        endcase
    endfunction

    // 111 is not a valid size. Stores have no zero-extending forms.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        return (f3 == F3_ILL) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/rv_dmem_resp_if.sv
// ---------------------------------------------------------------------------
// rv_dmem_resp_if
//   Request/response bus between the core (master) and the data-memory
//   responder (slave).
//   Request : req_valid_i, req_ready_o, req_we_i, req_addr_i (byte address),
//             req_wdata_i (right-aligned), req_funct3_i
//   Response: rsp_valid_o, rsp_ready_i, rsp_rdata_o, rsp_err_o
//   Each signal keeps the suffix that matches its direction at the responder.
// ---------------------------------------------------------------------------
interface rv_dmem_resp_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i
    );

endinterface

// File: rtl/rv_dmem_align.sv
// ---------------------------------------------------------------------------
// rv_dmem_align
//   Combinational lane logic for one 64-bit storage word.
//   funct3_i      : access size/sign code
//   offset_i      : byte lane offset inside the word (addr[2:0])
//   word_i        : current contents of the addressed word
//   wdata_i       : right-aligned store data
//   load_data_o   : lanes at the offset, sign- or zero-extended to 64 bits
//   merged_word_o : word_i with the selected lanes replaced by low wdata bytes
// ---------------------------------------------------------------------------
module rv_dmem_align
    import rv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] word_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_data_o,
    output logic [63:0] merged_word_o
);

    logic [5:0]  shamt;
    logic [63:0] lanes;
    logic [63:0] size_mask;
    logic [63:0] lane_mask;

    assign shamt = {offset_i, 3'b000};

    // NOTE: every signal written in always_comb gets a default value first.
    // If any path leaves a signal unassigned, synthesis infers a latch.
    always_comb begin
        lanes       = word_i >> shamt;
        load_data_o = '0;

        case (funct3_i[1:0])
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase

        lane_mask     = size_mask << shamt;
        merged_word_o = (word_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);

        case (funct3_i)
            F3_B:    load_data_o = {{56{lanes[7]}},  lanes[7:0]};
            F3_H:    load_data_o = {{48{lanes[15]}}, lanes[15:0]};
            F3_W:    load_data_o = {{32{lanes[31]}}, lanes[31:0]};
            F3_D:    load_data_o = lanes;
            F3_BU:   load_data_o = {56'd0, lanes[7:0]};
            F3_HU:   load_data_o = {48'd0, lanes[15:0]};
            F3_WU:   load_data_o = {32'd0, lanes[31:0]};
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_dmem_resp.sv
// ---------------------------------------------------------------------------
// rv_dmem_resp
//   Data-memory responder for an RV64 core. Each request is handled in turn
//   by the FSM IDLE -> ACCESS -> RESP. The memory access happens
//   WAIT_CYCLES+1 edges after the accept edge. Misaligned, out-of-range and
//   illegal-funct3 accesses return err=1 and rdata=0 and do not write
//   storage. Their timing is the same as a good access.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : rv_dmem_resp_if slave port (request and response handshakes)
// ---------------------------------------------------------------------------
module rv_dmem_resp
    import rv_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rstn,
    rv_dmem_resp_if.slave bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [63:0] mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [63:0] cur_word;
    logic [63:0] load_data;
    logic [63:0] merged_word;
    logic        out_of_range;
    logic        access_err;
    logic        mem_we;

    // Only the low index bits select the word. An out-of-range address is
    // caught by the full-width compare and never reads or writes storage.
    assign word_idx     = addr_q[3 +: IDX_W];
    assign cur_word     = mem_q[word_idx];
    assign out_of_range = addr_q[63:3] >= 61'(DEPTH_WORDS);
    assign access_err   = out_of_range
                        || f3_illegal(funct3_q, we_q)
                        || f3_misaligned(funct3_q, addr_q[2:0]);

    rv_dmem_align u_align (
        .funct3_i      (funct3_q),
        .offset_i      (addr_q[2:0]),
        .word_i        (cur_word),
        .wdata_i       (wdata_q),
        .load_data_o   (load_data),
        .merged_word_o (merged_word)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // req_ready_o is 1 throughout IDLE, so valid alone accepts.
                if (bus.req_valid_i) begin
                    addr_d   = bus.req_addr_i;
                    wdata_d  = bus.req_wdata_i;
                    we_d     = bus.req_we_i;
                    funct3_d = bus.req_funct3_i;
                    cnt_d    = 4'(WAIT_CYCLES);
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we      = we_q && !access_err;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = access_err;
                    rsp_rdata_d = (we_q || access_err) ? 64'd0 : load_data;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. All flops then
    // update together on the edge, and reads see the values from before it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: the storage array has no reset, so it maps onto plain RAM.
    // A reset still stops a pending store: reset forces state_q to IDLE at
    // once, and that clears mem_we before the access edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_rv_dmem_resp
//   Self-checking bench for rv_dmem_resp. A byte-array reference model
//   computes the expected rdata and err of every access from the
//   size, alignment and range rules. The directed scenarios also compare
//   against fixed constants.
// ---------------------------------------------------------------------------
module tb_rv_dmem_resp;

    localparam int DEPTH = 512;
    localparam int WAIT  = 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rv_dmem_resp_if bus ();

    rv_dmem_resp #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference storage, one entry per byte.
    logic [7:0] ref_mem [0:DEPTH*8-1];

    logic [63:0] rd, rd0, a, d;
    logic        e;
    logic        we_r;
    logic [2:0]  f3_r;
    int          lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Applies one access to the reference model and returns what the
    // responder must report for it.
    function automatic void model(input logic we, input logic [63:0] addr,
                                  input logic [63:0] wdata, input logic [2:0] f3,
                                  output logic [63:0] exp_rd, output logic exp_err);
        int size;
        size    = 1 << f3[1:0];
        exp_err = (f3 == 3'b111) || (we && f3 >= 3'b100)
               || (addr % 64'(size) != 64'd0) || (addr / 64'd8 >= 64'(DEPTH));
        exp_rd  = '0;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++)
                    exp_rd = exp_rd | (64'(ref_mem[int'(addr) + i]) << (8*i));
                if (f3 < 3'b100 && size < 8 && exp_rd[8*size-1])
                    exp_rd = exp_rd | (~64'd0 << (8*size));
            end
        end
    endfunction

    // Presents a request and returns #1 after its accept edge.
    task automatic send_req(input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [2:0] f3);
        int n;
        n = 0;
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        bus.req_funct3_i = f3;
        while (bus.req_ready_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_before_accept", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    // Counts the edges after the accept edge until rsp_valid_o is seen.
    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic finish_rsp();
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        check("rsp_valid_after_handshake", 64'(bus.rsp_valid_o), 64'd0);
        check("req_ready_after_handshake", 64'(bus.req_ready_o), 64'd1);
    endtask

    // Runs one full transaction and checks it against the reference model.
    task automatic txn(input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [2:0] f3,
                       output logic [63:0] obs_rd, output logic obs_err);
        int          n;
        logic [63:0] exp_rd;
        logic        exp_err;
        send_req(we, addr, wdata, f3);
        wait_rsp(n);
        check({tag, "_latency"}, 64'(n), 64'(WAIT + 1));
        obs_rd  = bus.rsp_rdata_o;
        obs_err = bus.rsp_err_o;
        model(we, addr, wdata, f3, exp_rd, exp_err);
        check({tag, "_rdata"}, obs_rd, exp_rd);
        check({tag, "_err"}, 64'(obs_err), 64'(exp_err));
        finish_rsp();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.req_funct3_i = '0;
        bus.rsp_ready_i  = 1'b0;

        // Reset state
        #12;
        check("reset_req_ready", 64'(bus.req_ready_o), 64'd1);
        check("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("reset_rsp_rdata", bus.rsp_rdata_o, 64'd0);
        check("reset_rsp_err",   64'(bus.rsp_err_o),   64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Doubleword store and load-back
        txn("sd_10", 1'b1, 64'h10, 64'h1122334455667788, 3'b011, rd, e);
        check("sd_10_err_const", 64'(e), 64'd0);
        txn("ld_10", 1'b0, 64'h10, 64'd0, 3'b011, rd, e);
        check("ld_10_const", rd, 64'h1122334455667788);

        // Byte store inside the word, then signed, unsigned and full reads
        txn("sb_13", 1'b1, 64'h13, 64'hFF, 3'b000, rd, e);
        txn("lb_13", 1'b0, 64'h13, 64'd0, 3'b000, rd, e);
        check("lb_13_const", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        txn("lbu_13", 1'b0, 64'h13, 64'd0, 3'b100, rd, e);
        check("lbu_13_const", rd, 64'hFF);
        txn("ld_10b", 1'b0, 64'h10, 64'd0, 3'b011, rd, e);
        check("ld_10b_const", rd, 64'h11223344FF667788);

        // Misaligned accesses report an error and a bad store writes nothing
        txn("lw_12", 1'b0, 64'h12, 64'd0, 3'b010, rd, e);
        check("lw_12_err_const", 64'(e), 64'd1);
        check("lw_12_rdata_const", rd, 64'd0);
        txn("sh_11", 1'b1, 64'h11, 64'hABCD, 3'b001, rd, e);
        check("sh_11_err_const", 64'(e), 64'd1);
        txn("ld_10c", 1'b0, 64'h10, 64'd0, 3'b011, rd, e);
        check("ld_10c_const", rd, 64'h11223344FF667788);

        // Out of range, and the illegal funct3
        txn("ld_oor", 1'b0, 64'(8*DEPTH), 64'd0, 3'b011, rd, e);
        check("ld_oor_err_const", 64'(e), 64'd1);
        txn("f3_111", 1'b0, 64'h10, 64'd0, 3'b111, rd, e);
        check("f3_111_err_const", 64'(e), 64'd1);

        // Back-pressure: the response stays stable, and a waiting request is
        // accepted only after the response handshake
        send_req(1'b0, 64'h10, 64'd0, 3'b011);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b0;
        bus.req_addr_i   = 64'h14;
        bus.req_funct3_i = 3'b010;
        wait_rsp(lat);
        check("hold_first_latency", 64'(lat), 64'(WAIT + 1));
        rd0 = bus.rsp_rdata_o;
        check("hold_first_rdata", rd0, 64'h11223344FF667788);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
            check("hold_rsp_rdata", bus.rsp_rdata_o, rd0);
            check("hold_rsp_err",   64'(bus.rsp_err_o), 64'd0);
            check("hold_req_ready", 64'(bus.req_ready_o), 64'd0);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        check("hold_release_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("hold_no_same_edge_accept", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        check("hold_second_accepted", 64'(bus.req_ready_o), 64'd0);
        wait_rsp(lat);
        check("hold_second_latency", 64'(lat), 64'(WAIT + 1));
        check("hold_second_rdata", bus.rsp_rdata_o, 64'h0000_0000_1122_3344);
        finish_rsp();

        // Reset in ACCESS discards a store that has not been performed
        txn("sd_20", 1'b1, 64'h20, 64'hCAFEF00D12345678, 3'b011, rd, e);
        send_req(1'b1, 64'h20, 64'hDEADBEEFDEADBEEF, 3'b011);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("mid_reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("mid_reset_req_ready", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk); #1;
        check("mid_reset_rsp_valid_held", 64'(bus.rsp_valid_o), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        txn("ld_20", 1'b0, 64'h20, 64'd0, 3'b011, rd, e);
        check("ld_20_const", rd, 64'hCAFEF00D12345678);

        // Random traffic over a fully initialised region (words 0..15)
        for (int w = 0; w < 16; w++) begin
            d = {$urandom, $urandom};
            txn("init", 1'b1, 64'(8*w), d, 3'b011, rd, e);
        end
        for (int k = 0; k < 150; k++) begin
            we_r = 1'($urandom_range(0, 1));
            f3_r = 3'($urandom_range(0, 7));
            a    = 64'($urandom_range(0, 127));
            d    = {$urandom, $urandom};
            case ($urandom_range(0, 11))
                0: a = 64'(8*DEPTH) + 64'($urandom_range(0, 63));
                1: a = {1'b1, 55'd0, a[7:0]};
                default: ;
            endcase
            txn("rand", we_r, a, d, f3_r, rd, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_dmem_resp.md
RV_DMEM_RESP -- requirements
Module: rv_dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 512, number of 64-bit storage words.
REQ-002 Parameter WAIT_CYCLES, default 1, extra access cycles per request (0..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  core presents a load/store request.
REQ-006 req_ready_o  output  1  responder can accept a request.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_addr_i  input  64  byte address.
REQ-009 req_wdata_i  input  64  store data, right-aligned.
REQ-010 req_funct3_i  input  3  RV64 size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-011 rsp_valid_o  output  1  response available.
REQ-012 rsp_ready_i  input  1  core accepts response.
REQ-013 rsp_rdata_o  output  64  load data, extended per funct3; 0 for stores and errors.
REQ-014 rsp_err_o  output  1  misaligned, out-of-range or illegal-funct3 access.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-016 Handshake: request accepted on edge where req_valid_i & req_ready_o; addr, wdata, we and funct3 latched; wait counter loaded with WAIT_CYCLES; go to ACCESS.
REQ-017 In ACCESS: counter nonzero -> decrement; counter zero -> perform access, register response, go to RESP on the same edge.
REQ-018 Latency: rsp_valid_o rises after edge T0+WAIT_CYCLES+1, T0 = accept edge (WAIT_CYCLES=1 -> 2 cycles).
REQ-019 In RESP: rsp_valid_o, rsp_rdata_o and rsp_err_o held stable until rsp_ready_i=1; that edge returns to IDLE; no new request accepted on the same edge.
REQ-020 Word index = addr[63:3]; lane offset = addr[2:0].
REQ-021 Alignment: H requires addr[0]=0, W requires addr[1:0]=0, D requires addr[2:0]=0; violation -> err.
REQ-022 Range: word index >= DEPTH_WORDS -> err.
REQ-023 funct3 111, or stores with funct3 >= 100 -> err.
REQ-024 Error access: storage unmodified, rdata 0, err 1; FSM timing identical to a good access.
REQ-025 Store: only selected byte lanes of the addressed word are written (B 1, H 2, W 4, D 8 lanes), sourced from the low bytes of wdata.
REQ-026 Load: extract the lanes at the offset; B/H/W sign-extend to 64 bits, BU/HU/WU zero-extend, D unmodified.
REQ-027 Store response: rdata 0, err per REQ-021..023.
REQ-028 Read data reflects all stores completed before the access edge (read-after-write across transactions).
REQ-029 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-030 On rstn low: state IDLE, counter 0, req_ready_o 1, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0.
REQ-031 Reset mid-ACCESS discards the transaction; a store not yet performed SHALL NOT modify storage.
REQ-032 Storage array is not reset; contents are undefined until written.

Structure
REQ-033 funct3 encodings and FSM state encoding reside in shared package rv_pkg, shared with the core's decode.
REQ-034 Lane extract/extend and lane merge logic lives in one combinational sub-module rv_dmem_align; FSM and storage stay in rv_dmem_resp.

Verification
REQ-035 SD addr 0x10 data 0x1122334455667788, then LD 0x10 -> rdata 0x1122334455667788, err 0, rsp_valid 2 cycles after each accept.
REQ-036 SB addr 0x13 data 0xFF over the 0x10 word; LB 0x13 -> 0xFFFFFFFFFFFFFFFF; LBU 0x13 -> 0xFF; LD 0x10 -> 0x11223344FF667788.
REQ-037 LW addr 0x12 -> err 1, rdata 0; SH addr 0x11 -> err 1, following LD 0x10 unchanged.
REQ-038 LD addr 8*DEPTH_WORDS -> err 1; funct3 111 -> err 1.
REQ-039 Hold rsp_ready_i 0 for 5 cycles with req_valid_i 1 -> rsp_valid and data stable, req_ready 0, second request accepted only after response handshake.
REQ-040 Assert rstn low one cycle after accepting SD 0x20 -> rsp_valid 0, req_ready 1; later LD 0x20 returns the prior contents.
